instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
Converts field-level instruction descriptions into 32-bit instruction words, using the same field layout that the control unit decodes. Each encoded word is written sequentially into instruction memory starting at a base address. It is the writer side of the instruction stream: the program loader / test-stimulus front end that fills memory for the fetch/decode path. Input is a valid/ready stream; encoded words are buffered in a FIFO and drained through a stallable memory-write port.

Parameters:
DEPTH, 4, encoded-word FIFO entries (power of 2, >=2)
ADDR_W, 8, instruction memory byte-address width
BASE_ADDR, 0, first write address of every stream (word aligned)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
enc_valid  in  1  field bundle valid
enc_ready  out  1  block can accept a bundle this cycle
enc_last  in  1  marks final bundle of a program
enc_type  in  2  00 data-proc, 01 load/store, 10 branch, 11 NOP
enc_cond  in  4  condition code
enc_imm  in  1  immediate flag
enc_opcode  in  4  DP opcode, or P/U/B/W bits for load/store
enc_s  in  1  set-flags request
enc_load  in  1  load/store direction: 1 load, 0 store
enc_link  in  1  branch-with-link
enc_rn  in  4  first operand register
enc_rd  in  4  destination register
enc_operand2  in  12  shifter operand / offset
enc_offset  in  24  branch word offset
imem_we  out  1  write request
imem_ready  in  1  memory accepts write this cycle
imem_addr  out  ADDR_W  byte address
imem_wdata  out  32  encoded word
word_count  out  ADDR_W  words written in current stream
done  out  1  one-cycle pulse after the last word is written

Behaviour:
- Encoding (combinational, registered into the FIFO): [31:28]=cond, [27:26]=type, [25]=imm, [24:21]=opcode, [20]=S, [19:16]=rn, [15:12]=rd, [11:0]=operand2.
- DP: S bit = enc_s, except opcodes 1000-1011 (TST/TEQ/CMP/CMN), which force S=1.
- Load/store: [20]=enc_load, and enc_s is ignored.
- Branch: [27:25]=101, [24]=enc_link, [23:0]=enc_offset. enc_imm, enc_opcode, enc_s, enc_rn, enc_rd and enc_operand2 are ignored.
- Type 11 (NOP): word is exactly 32'h00000000, all fields ignored (cond too).
- Handshake: a bundle is accepted on an edge where enc_valid && enc_ready. enc_ready depends on registered state only: ready = (state != FLUSH) && FIFO not full. No push is allowed on a full FIFO, even when a pop occurs in the same cycle.
- Output register: holds imem_we/addr/wdata.
  - It loads from the FIFO head when FIFO is non-empty and (!imem_we || imem_ready).
  - A write completes on an edge with imem_we && imem_ready.
  - While imem_ready=0, imem_we/addr/wdata are held stable.
- Latency: a bundle accepted on edge E is presented with imem_we=1 in the cycle after edge E+1 (FIFO empty, output idle). Back-to-back accepts give one write per cycle when imem_ready=1.
- Capacity: DEPTH FIFO entries plus one output register, so DEPTH+1 bundles are accepted with imem_ready held low.
- Address and count:
  - On completion, imem_addr advances by 4, wrapping modulo 2^ADDR_W, and word_count advances by 1, also wrapping.
  - The first accept from IDLE resets imem_addr to BASE_ADDR and word_count to 0.
- FSM:
  - IDLE -> STREAM on the first accept.
  - STREAM -> FLUSH when the accepted bundle has enc_last=1.
  - FLUSH -> IDLE on completion of the last word (FIFO empty, output register draining). done=1 for the following cycle.
  - An enc_last bundle accepted from IDLE goes directly to FLUSH.
- Reset values: imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_count=0, done=0, FIFO empty, state IDLE, enc_ready=1 in the cycle after reset deasserts.
- Reset mid-stream discards all buffered and in-flight words; no write completes on the reset edge.

Test Plan:
- DP: type 00, cond E, imm 1, opcode 0100, s 0, rn 1, rd 2, op2 005 -> imem_wdata=32'hE2812005 at addr 0, written 2 cycles after accept.
- CMP forced S: opcode 1010, s 0, imm 0, rn 3, rd 0, op2 004, cond E -> 32'hE1530004.
- Load/store: type 01, opcode 1100, load 1, rn 1 -> 32'hE5910000; same bundle with load 0 -> 32'hE5810000.
- Branch and NOP: offset 000003, link 0 -> 32'hEA000003; link 1 -> 32'hEB000003; type 11 with cond E -> 32'h00000000.
- Backpressure: DEPTH=4, imem_ready=0, 6 bundles offered -> 5 accepted, enc_ready low after the 5th. Then imem_ready=1 -> 5 writes in consecutive cycles with correct order and addresses 0,4,8,C,10.
- Wrap, done and reset: ADDR_W=8, BASE_ADDR=FC, two bundles with last on the 2nd -> addresses FC then 00, word_count=2, done pulses exactly once. Reset asserted with 3 words buffered -> no further imem_we, imem_addr=FC.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs field-level instruction bundles into 32-bit words and streams them into
// instruction memory through a small FIFO and a stallable output register.
module instruction_encoder #(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic              enc_last,
    input  logic [1:0]        enc_type,
    input  logic [3:0]        enc_cond,
    input  logic              enc_imm,
    input  logic [3:0]        enc_opcode,
    input  logic              enc_s,
    input  logic              enc_load,
    input  logic              enc_link,
    input  logic [3:0]        enc_rn,
    input  logic [3:0]        enc_rd,
    input  logic [11:0]       enc_operand2,
    input  logic [23:0]       enc_offset,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W-1:0] word_count,
    output logic              done
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                done_q, done_d;

    logic [31:0]         fifo_mem [DEPTH];
    logic [31:0]         fifo_head;
    logic [31:0]         enc_word;
    logic                s_eff;
    logic                fifo_full, fifo_empty;
    logic                push, pop, complete;

    // Compare-class opcodes (1000-1011) always update flags.
    assign s_eff = enc_s | (enc_opcode[3:2] == 2'b10);

    always_comb begin
        enc_word = '0;
        case (enc_type)
            2'b00:   enc_word = {enc_cond, 2'b00, enc_imm, enc_opcode, s_eff,
                                 enc_rn, enc_rd, enc_operand2};
            2'b01:   enc_word = {enc_cond, 2'b01, enc_imm, enc_opcode, enc_load,
                                 enc_rn, enc_rd, enc_operand2};
            2'b10:   enc_word = {enc_cond, 3'b101, enc_link, enc_offset};
            default: enc_word = '0;
        endcase
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    // Ready is purely registered: a pop in the same cycle never frees a full slot.
    assign enc_ready = (state_q != FLUSH) && !fifo_full;
    assign push      = enc_valid && enc_ready;
    assign complete  = we_q && imem_ready;
    assign pop       = !fifo_empty && (!we_q || imem_ready);

    assign wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= enc_word;
        end
    end

    always_comb begin
        we_d    = we_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        count_d = count_q;
        if (pop) begin
            we_d    = 1'b1;
            wdata_d = fifo_head;
        end else if (complete) begin
            we_d = 1'b0;
        end
        if (state_q == IDLE && push) begin
            addr_d  = BASE_ADDR;
            count_d = '0;
        end else if (complete) begin
            addr_d  = addr_q + ADDR_W'(4);
            count_d = count_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = enc_last ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                if (push && enc_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Nothing is pushed in FLUSH, so an empty FIFO means this is the last word.
                if (complete && fifo_empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized and directed bench for instruction_encoder; two instances differ only in
// BASE_ADDR (0 and FC) so address wrap is exercised alongside the plain layout.
module tb_instruction_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enc_valid, enc_last, enc_imm, enc_s, enc_load, enc_link, imem_ready;
    logic [1:0]  enc_type;
    logic [3:0]  enc_cond, enc_opcode, enc_rn, enc_rd;
    logic [11:0] enc_operand2;
    logic [23:0] enc_offset;

    logic        enc_ready0, imem_we0, done0, enc_ready1, imem_we1, done1;
    logic [7:0]  addr0, wc0, addr1, wc1;
    logic [31:0] wdata0, wdata1;

    instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .reset(reset), .enc_valid(enc_valid), .enc_ready(enc_ready0),
        .enc_last(enc_last), .enc_type(enc_type), .enc_cond(enc_cond), .enc_imm(enc_imm),
        .enc_opcode(enc_opcode), .enc_s(enc_s), .enc_load(enc_load), .enc_link(enc_link),
        .enc_rn(enc_rn), .enc_rd(enc_rd), .enc_operand2(enc_operand2), .enc_offset(enc_offset),
        .imem_we(imem_we0), .imem_ready(imem_ready), .imem_addr(addr0), .imem_wdata(wdata0),
        .word_count(wc0), .done(done0));

    instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(8'hFC)) dut1 (
        .clk(clk), .reset(reset), .enc_valid(enc_valid), .enc_ready(enc_ready1),
        .enc_last(enc_last), .enc_type(enc_type), .enc_cond(enc_cond), .enc_imm(enc_imm),
        .enc_opcode(enc_opcode), .enc_s(enc_s), .enc_load(enc_load), .enc_link(enc_link),
        .enc_rn(enc_rn), .enc_rd(enc_rd), .enc_operand2(enc_operand2), .enc_offset(enc_offset),
        .imem_we(imem_we1), .imem_ready(imem_ready), .imem_addr(addr1), .imem_wdata(wdata1),
        .word_count(wc1), .done(done1));

    typedef struct {
        logic [1:0]  typ;
        logic [3:0]  cond;
        logic        imm;
        logic [3:0]  opc;
        logic        s, load, link;
        logic [3:0]  rn, rd;
        logic [11:0] op2;
        logic [23:0] off;
    } bundle_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_data0[$], got_data1[$];
    logic [7:0]  got_addr0[$], got_addr1[$];
    int          done_cnt0 = 0, done_cnt1 = 0;

    // Completed writes, sampled half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!reset && imem_we0 && imem_ready) begin
            got_data0.push_back(wdata0);
            got_addr0.push_back(addr0);
        end
        if (!reset && imem_we1 && imem_ready) begin
            got_data1.push_back(wdata1);
            got_addr1.push_back(addr1);
        end
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    // Reference encoder built from the field-placement rules.
    function automatic logic [31:0] ref_word(input bundle_t b);
        logic [31:0] w;
        logic        sbit;
        w = 32'h0;
        case (b.typ)
            2'd0: begin
                sbit = b.s || (b.opc >= 4'd8 && b.opc <= 4'd11);
                w = (32'(b.cond) << 28) | (32'(b.imm) << 25) | (32'(b.opc) << 21) |
                    (32'(sbit) << 20) | (32'(b.rn) << 16) | (32'(b.rd) << 12) | 32'(b.op2);
            end
            2'd1: w = (32'(b.cond) << 28) | (32'd1 << 26) | (32'(b.imm) << 25) |
                      (32'(b.opc) << 21) | (32'(b.load) << 20) | (32'(b.rn) << 16) |
                      (32'(b.rd) << 12) | 32'(b.op2);
            2'd2: w = (32'(b.cond) << 28) | (32'd5 << 25) | (32'(b.link) << 24) | 32'(b.off);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.typ  = 2'($urandom);  b.cond = 4'($urandom); b.imm  = 1'($urandom);
        b.opc  = 4'($urandom);  b.s    = 1'($urandom); b.load = 1'($urandom);
        b.link = 1'($urandom);  b.rn   = 4'($urandom); b.rd   = 4'($urandom);
        b.op2  = 12'($urandom); b.off  = 24'($urandom);
        return b;
    endfunction

    task automatic apply(input bundle_t b, input logic last);
        enc_type = b.typ; enc_cond = b.cond; enc_imm = b.imm; enc_opcode = b.opc;
        enc_s = b.s; enc_load = b.load; enc_link = b.link; enc_rn = b.rn; enc_rd = b.rd;
        enc_operand2 = b.op2; enc_offset = b.off; enc_last = last;
    endtask

    // Offers one bundle until accepted; returns at posedge+1 after the accepting edge.
    task automatic send(input bundle_t b, input logic last, input bit rand_ready);
        bit acc, ok;
        ok = 0;
        apply(b, last);
        enc_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            acc = enc_ready0;
            @(posedge clk);
            #1;
            if (rand_ready) imem_ready = 1'($urandom_range(0, 1));
            if (acc) begin
                ok = 1;
                exp_q.push_back(ref_word(b));
                break;
            end
        end
        enc_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: enc_ready stayed %b, required 1 within 200 cycles", enc_ready0);
        end
    endtask

    // Returns at the negedge where done0 is high.
    task automatic wait_done(input int max_cycles, input bit rand_ready);
        bit seen;
        seen = 0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (done0) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (rand_ready) imem_ready = 1'($urandom_range(0, 1));
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: done=%b, required 1 within %0d cycles", done0, max_cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enc_valid = 1'b0; imem_ready = 1'b0;
        apply(rand_bundle(), 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if ({imem_we0, imem_we1, done0, done1} !== 4'b0) begin bad++;
            $display("FAIL reset_flags: we/done=%b required 0000", {imem_we0, imem_we1, done0, done1}); end
        total++; if (addr0 !== 8'h00 || addr1 !== 8'hFC) begin bad++;
            $display("FAIL reset_addr: got %h/%h required 00/fc", addr0, addr1); end
        total++; if (wdata0 !== 32'h0 || wdata1 !== 32'h0) begin bad++;
            $display("FAIL reset_wdata: got %h/%h required 0", wdata0, wdata1); end
        total++; if (wc0 !== 8'h0 || wc1 !== 8'h0) begin bad++;
            $display("FAIL reset_count: got %h/%h required 0", wc0, wc1); end
        total++; if (enc_ready0 !== 1'b1 || enc_ready1 !== 1'b1) begin bad++;
            $display("FAIL reset_ready: got %b/%b required 1", enc_ready0, enc_ready1); end
        @(posedge clk); #1;
    endtask

    // Directed single-bundle programs with hand-derived words and latency/done timing.
    task automatic test_encodings();
        logic [1:0]  t_typ [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        logic [3:0]  t_opc [7] = '{4'h4, 4'hA, 4'hC, 4'hC, 4'hF, 4'h3, 4'h4};
        logic        t_imm [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        t_s   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        t_ld  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        t_lnk [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0]  t_rn  [7] = '{4'h1, 4'h3, 4'h1, 4'h1, 4'h7, 4'h9, 4'h5};
        logic [3:0]  t_rd  [7] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h6, 4'h8, 4'h5};
        logic [11:0] t_op2 [7] = '{12'h005, 12'h004, 12'h000, 12'h000, 12'hABC, 12'h123, 12'hFFF};
        logic [31:0] t_exp [7] = '{32'hE2812005, 32'hE1530004, 32'hE5910000, 32'hE5810000,
                                   32'hEA000003, 32'hEB000003, 32'h00000000};
        bundle_t b;
        for (int i = 0; i < 7; i++) begin
            b.typ = t_typ[i]; b.cond = 4'hE; b.imm = t_imm[i]; b.opc = t_opc[i];
            b.s = t_s[i]; b.load = t_ld[i]; b.link = t_lnk[i]; b.rn = t_rn[i];
            b.rd = t_rd[i]; b.op2 = t_op2[i]; b.off = 24'h000003;
            imem_ready = 1'b1;
            send(b, 1'b1, 1'b0);
            @(negedge clk);
            total++; if (imem_we0 !== 1'b0) begin bad++;
                $display("FAIL enc%0d_early_we: imem_we=%b required 0 one cycle after accept", i, imem_we0); end
            @(negedge clk);
            total++; if (imem_we0 !== 1'b1 || wdata0 !== t_exp[i]) begin bad++;
                $display("FAIL enc%0d_word: we=%b wdata=%h required we=1 wdata=%h", i, imem_we0, wdata0, t_exp[i]); end
            total++; if (addr0 !== 8'h00 || addr1 !== 8'hFC || wdata1 !== t_exp[i]) begin bad++;
                $display("FAIL enc%0d_addr: addr=%h/%h wdata1=%h required 00/fc %h", i, addr0, addr1, wdata1, t_exp[i]); end
            @(negedge clk);
            total++; if (done0 !== 1'b1 || wc0 !== 8'd1) begin bad++;
                $display("FAIL enc%0d_done: done=%b count=%0d required done=1 count=1", i, done0, wc0); end
            @(negedge clk);
            total++; if (done0 !== 1'b0) begin bad++;
                $display("FAIL enc%0d_done_pulse: done=%b required 0 on second cycle", i, done0); end
            @(posedge clk); #1;
        end
    endtask

    // Fill with memory stalled, then drain at one write per cycle.
    task automatic test_back_to_back();
        bundle_t b[6];
        bit      acc;
        for (int i = 0; i < 6; i++) b[i] = rand_bundle();
        imem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apply(b[i], 1'b0);
            enc_valid = 1'b1;
            @(negedge clk);
            acc = enc_ready0;
            total++; if (enc_ready0 !== (i < 5)) begin bad++;
                $display("FAIL bp_ready%0d: enc_ready=%b required %b", i, enc_ready0, (i < 5)); end
            if (i >= 2) begin
                total++; if (imem_we0 !== 1'b1 || wdata0 !== ref_word(b[0]) || addr0 !== 8'h00) begin bad++;
                    $display("FAIL bp_hold%0d: we=%b wdata=%h addr=%h required 1 %h 00", i, imem_we0, wdata0, addr0, ref_word(b[0])); end
            end
            @(posedge clk); #1;
            if (acc) exp_q.push_back(ref_word(b[i]));
        end
        enc_valid = 1'b0;
        imem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (imem_we0 !== 1'b1 || wdata0 !== ref_word(b[k]) || addr0 !== 8'(4 * k)) begin bad++;
                $display("FAIL bp_drain%0d: we=%b wdata=%h addr=%h required 1 %h %h", k, imem_we0, wdata0, addr0, ref_word(b[k]), 8'(4 * k)); end
        end
        @(posedge clk); #1;
        send(b[5], 1'b1, 1'b0);
        wait_done(20, 1'b0);
        total++; if (wc0 !== 8'd6) begin bad++;
            $display("FAIL bp_count: word_count=%0d required 6", wc0); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_done();
        int      n0, d1;
        bundle_t b0, b1;
        b0 = rand_bundle(); b1 = rand_bundle();
        n0 = got_addr1.size(); d1 = done_cnt1;
        imem_ready = 1'b1;
        send(b0, 1'b0, 1'b0);
        send(b1, 1'b1, 1'b0);
        wait_done(20, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        total++; if (got_addr1.size() != n0 + 2) begin bad++;
            $display("FAIL wrap_writes: %0d writes, required 2", got_addr1.size() - n0); end
        else begin
            total++; if (got_addr1[n0] !== 8'hFC || got_addr1[n0+1] !== 8'h00) begin bad++;
                $display("FAIL wrap_addr: got %h,%h required fc,00", got_addr1[n0], got_addr1[n0+1]); end
            total++; if (got_data1[n0] !== ref_word(b0) || got_data1[n0+1] !== ref_word(b1)) begin bad++;
                $display("FAIL wrap_data: got %h,%h required %h,%h", got_data1[n0], got_data1[n0+1], ref_word(b0), ref_word(b1)); end
        end
        total++; if (wc1 !== 8'd2 || addr1 !== 8'h04) begin bad++;
            $display("FAIL wrap_count: count=%0d addr=%h required 2 04", wc1, addr1); end
        total++; if (done_cnt1 - d1 != 1) begin bad++;
            $display("FAIL wrap_done: %0d done pulses, required 1", done_cnt1 - d1); end
    endtask

    // Long random program with random memory stalls against the scoreboard.
    task automatic test_random();
        int n0, e0, d0, errs;
        n0 = got_data0.size(); e0 = exp_q.size(); d0 = done_cnt0; errs = 0;
        for (int i = 0; i < 40; i++) send(rand_bundle(), (i == 39), 1'b1);
        wait_done(500, 1'b1);
        @(posedge clk); #1;
        total++; if (got_data0.size() - n0 != 40 || got_data1.size() - n0 != 40) begin bad++;
            $display("FAIL rand_writes: %0d/%0d writes, required 40", got_data0.size() - n0, got_data1.size() - n0); end
        else begin
            for (int i = 0; i < 40; i++) begin
                if (got_data0[n0+i] !== exp_q[e0+i] || got_data1[n0+i] !== exp_q[e0+i] ||
                    got_addr0[n0+i] !== 8'(4 * i) || got_addr1[n0+i] !== 8'(8'hFC + 4 * i)) begin
                    errs++;
                    if (errs < 4) $display("FAIL rand_word%0d: data=%h addr=%h/%h required %h %h/%h", i,
                        got_data0[n0+i], got_addr0[n0+i], got_addr1[n0+i], exp_q[e0+i], 8'(4 * i), 8'(8'hFC + 4 * i));
                end
            end
            total++; if (errs != 0) bad++;
        end
        total++; if (wc0 !== 8'd40 || done_cnt0 - d0 != 1) begin bad++;
            $display("FAIL rand_end: count=%0d done pulses=%0d required 40 1", wc0, done_cnt0 - d0); end
    endtask

    task automatic test_reset_midstream();
        int n0, we_seen;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_bundle(), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n0 = got_data0.size(); we_seen = 0;
        reset = 1'b1; imem_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (enc_ready0 !== 1'b1 || addr1 !== 8'hFC || addr0 !== 8'h00 || wc0 !== 8'd0) begin bad++;
            $display("FAIL rst_state: ready=%b addr=%h/%h count=%0d required 1 00/fc 0", enc_ready0, addr0, addr1, wc0); end
        for (int c = 0; c < 8; c++) begin
            if (imem_we0 || imem_we1) we_seen++;
            @(negedge clk);
        end
        total++; if (we_seen != 0 || got_data0.size() != n0) begin bad++;
            $display("FAIL rst_flush: %0d write cycles after reset, required 0", we_seen); end
        total++; if (addr1 !== 8'hFC || done0 !== 1'b0) begin bad++;
            $display("FAIL rst_hold: addr=%h done=%b required fc 0", addr1, done0); end
    endtask

    initial begin
        reset = 1'b1; enc_valid = 1'b0; enc_last = 1'b0; imem_ready = 1'b0;
        test_reset();
        test_encodings();
        test_back_to_back();
        test_wrap_done();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
